// File: rtl/myo_spi_slave.sv
// -----------------------------------------------------------------------------
// myo_spi_slave
//
// SPI responder (mode 0, MSB first) for the motor-board end of the myo SPI
// link. The sck, ss_n and mosi inputs are oversampled in the local clock
// domain. Each frame carries NUM_WORDS words of WORD_W bits. Received words
// are presented on rx_word, one word at a time. During the same frame a status
// word stream is shifted out on miso; the words come from tx_word, selected by
// tx_word_idx. On the rising edge of ss_n the frame is flagged as complete
// (frame_done) or malformed (frame_error).
//
// Optional build macro:
//   MYO_SPI_TIMEOUT_EN - adds a stall watchdog. If no synced sck edge arrives
//                        for TIMEOUT_CYC cycles in ACTIVE, frame_error pulses,
//                        miso_oe drops, and the block waits in WAIT_HIGH until
//                        ss_n goes high. Without the macro, a stalled frame
//                        stays ACTIVE.
//
// Ports:
//   clock          in   system clock, at least 8x the sck rate
//   reset_n        in   asynchronous active-low reset
//   sck            in   SPI clock from master (CPOL=0, CPHA=0)
//   ss_n           in   slave select, active low
//   mosi           in   master-out data
//   miso           out  slave-out data
//   miso_oe        out  high while a frame is active (board tristates miso)
//   tx_word        in   word to transmit at index tx_word_idx
//   tx_word_idx    out  index of the next word to be loaded into tx shifter
//   rx_word        out  last received word
//   rx_word_idx    out  index of rx_word within the frame
//   rx_word_valid  out  one-cycle pulse when rx_word/rx_word_idx update
//   frame_done     out  one-cycle pulse: frame had exactly NUM_WORDS words
//   frame_error    out  one-cycle pulse: short, partial, overrun or stalled
//   busy           out  high in ACTIVE
// -----------------------------------------------------------------------------
module myo_spi_slave #(
  parameter int WORD_W      = 16,
  parameter int NUM_WORDS   = 12,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [WORD_W-1:0] tx_word,
  output logic [IDX_W-1:0]  tx_word_idx,
  output logic [WORD_W-1:0] rx_word,
  output logic [IDX_W-1:0]  rx_word_idx,
  output logic              rx_word_valid,
  output logic              frame_done,
  output logic              frame_error,
  output logic              busy
);

  // word_cnt saturates at NUM_WORDS+1 to mark an overrun
  localparam int WCNT_W = $clog2(NUM_WORDS + 2);
  localparam int BIT_W  = $clog2(WORD_W);

  localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(NUM_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_SAT  = WCNT_W'(NUM_WORDS + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NUM_WORDS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_WORDS - 1);

  // Bit order inside a synchronizer stage: {mosi, ss_n, sck}. ss_n resets high.
  localparam logic [2:0] SYNC_RST = 3'b010;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("myo_spi_slave: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("myo_spi_slave: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1
`ifdef MYO_SPI_TIMEOUT_EN
    , ST_WAIT_HIGH = 2'd2
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [2:0] sync_q [SYNC_STAGES];

  genvar gi;
  for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q[gi] <= SYNC_RST;
        else          sync_q[gi] <= {mosi, ss_n, sck};
      end
    end else begin : g_rest
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q[gi] <= SYNC_RST;
        else          sync_q[gi] <= sync_q[gi-1];
      end
    end
  end

  logic sck_s, ss_s, mosi_s;
  assign sck_s  = sync_q[SYNC_STAGES-1][0];
  assign ss_s   = sync_q[SYNC_STAGES-1][1];
  assign mosi_s = sync_q[SYNC_STAGES-1][2];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic                sck_prev_q, ss_prev_q;
  // settle_q[top] is set once the last sync stage holds a real pin sample
  // rather than its reset value. armed_q is set once ss_n has been seen high.
  // A frame already in progress at reset release can therefore never start.
  logic [SYNC_STAGES-1:0] settle_q;
  logic                armed_q, armed_d;
  logic [WORD_W-1:0]   rx_shift_q, rx_shift_d;
  logic [WORD_W-1:0]   tx_shift_q, tx_shift_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [IDX_W-1:0]    tx_word_idx_q, tx_word_idx_d;
  logic [WORD_W-1:0]   rx_word_q, rx_word_d;
  logic [IDX_W-1:0]    rx_word_idx_q, rx_word_idx_d;
  logic                rx_word_valid_q, rx_word_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_error_q, frame_error_d;
  logic                miso_q, miso_d;
  logic                miso_oe_q, miso_oe_d;

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;

  logic [WORD_W-1:0] rx_next;
  assign rx_next = {rx_shift_q[WORD_W-2:0], mosi_s};

`ifdef MYO_SPI_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] timeout_q, timeout_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) timeout_q <= '0;
    else          timeout_q <= timeout_d;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      sck_prev_q      <= 1'b0;
      ss_prev_q       <= 1'b1;
      settle_q        <= '0;
      armed_q         <= 1'b0;
      rx_shift_q      <= '0;
      tx_shift_q      <= '0;
      bit_cnt_q       <= '0;
      word_cnt_q      <= '0;
      tx_word_idx_q   <= '0;
      rx_word_q       <= '0;
      rx_word_idx_q   <= '0;
      rx_word_valid_q <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_error_q   <= 1'b0;
      miso_q          <= 1'b0;
      miso_oe_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      sck_prev_q      <= sck_s;
      ss_prev_q       <= ss_s;
      settle_q        <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      armed_q         <= armed_d;
      rx_shift_q      <= rx_shift_d;
      tx_shift_q      <= tx_shift_d;
      bit_cnt_q       <= bit_cnt_d;
      word_cnt_q      <= word_cnt_d;
      tx_word_idx_q   <= tx_word_idx_d;
      rx_word_q       <= rx_word_d;
      rx_word_idx_q   <= rx_word_idx_d;
      rx_word_valid_q <= rx_word_valid_d;
      frame_done_q    <= frame_done_d;
      frame_error_q   <= frame_error_d;
      miso_q          <= miso_d;
      miso_oe_q       <= miso_oe_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    armed_d         = armed_q | (settle_q[SYNC_STAGES-1] & ss_s);
    rx_shift_d      = rx_shift_q;
    tx_shift_d      = tx_shift_q;
    bit_cnt_d       = bit_cnt_q;
    word_cnt_d      = word_cnt_q;
    tx_word_idx_d   = tx_word_idx_q;
    rx_word_d       = rx_word_q;
    rx_word_idx_d   = rx_word_idx_q;
    rx_word_valid_d = 1'b0;
    frame_done_d    = 1'b0;
    frame_error_d   = 1'b0;
    miso_d          = miso_q;
    miso_oe_d       = miso_oe_q;
`ifdef MYO_SPI_TIMEOUT_EN
    if (sck_rise || sck_fall)    timeout_d = '0;
    else if (state_q == ST_ACTIVE) timeout_d = timeout_q + TO_W'(1);
    else                         timeout_d = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        miso_d        = 1'b0;
        miso_oe_d     = 1'b0;
        tx_word_idx_d = '0;
        if (ss_fall && armed_q) begin
          tx_shift_d = tx_word;
          miso_d     = tx_word[WORD_W-1];
          miso_oe_d  = 1'b1;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = ST_ACTIVE;
`ifdef MYO_SPI_TIMEOUT_EN
          timeout_d  = '0;
`endif
        end
      end

      ST_ACTIVE: begin
        if (ss_rise) begin
          // End of frame wins over any sck edge seen in the same cycle
          if (word_cnt_q == WCNT_FULL && bit_cnt_q == '0) frame_done_d  = 1'b1;
          else                                             frame_error_d = 1'b1;
          miso_d        = 1'b0;
          miso_oe_d     = 1'b0;
          tx_word_idx_d = '0;
          state_d       = ST_IDLE;
        end else if (sck_rise) begin
          rx_shift_d = rx_next;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (word_cnt_q < WCNT_FULL) begin
              rx_word_d       = rx_next;
              rx_word_idx_d   = IDX_W'(word_cnt_q);
              rx_word_valid_d = 1'b1;
            end
            if (word_cnt_q != WCNT_SAT) word_cnt_d = word_cnt_q + WCNT_W'(1);
            // Request the next tx word early so it is stable by the next fall
            tx_word_idx_d = (word_cnt_q >= WCNT_LAST) ? IDX_LAST
                                                      : IDX_W'(word_cnt_q + WCNT_W'(1));
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else if (sck_fall) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
            miso_d     = tx_shift_q[WORD_W-2];
          end else if (word_cnt_q != '0) begin
            // Word boundary: words past the end of a frame shift out zeros
            tx_shift_d = (word_cnt_q < WCNT_FULL) ? tx_word : '0;
            miso_d     = (word_cnt_q < WCNT_FULL) ? tx_word[WORD_W-1] : 1'b0;
          end
        end
`ifdef MYO_SPI_TIMEOUT_EN
        else if (timeout_q == TO_LAST) begin
          frame_error_d = 1'b1;
          miso_d        = 1'b0;
          miso_oe_d     = 1'b0;
          tx_word_idx_d = '0;
          state_d       = ST_WAIT_HIGH;
        end
`endif
      end

`ifdef MYO_SPI_TIMEOUT_EN
      ST_WAIT_HIGH: begin
        miso_d        = 1'b0;
        miso_oe_d     = 1'b0;
        tx_word_idx_d = '0;
        if (ss_s) state_d = ST_IDLE;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign miso          = miso_q;
  assign miso_oe       = miso_oe_q;
  assign tx_word_idx   = tx_word_idx_q;
  assign rx_word       = rx_word_q;
  assign rx_word_idx   = rx_word_idx_q;
  assign rx_word_valid = rx_word_valid_q;
  assign frame_done    = frame_done_q;
  assign frame_error   = frame_error_q;
  assign busy          = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_myo_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_myo_spi_slave
//
// Directed bench for myo_spi_slave. A behavioural mode-0 SPI master runs sck at
// clock/8. A monitor records every rx_word_valid, frame_done and frame_error
// pulse. Expected values are fixed by the stimulus: the master sends
// base+index, and tx_word is 0xA000+tx_word_idx.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_myo_spi_slave;
  localparam int WORD_W      = 16;
  localparam int NUM_WORDS   = 12;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 64;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sck = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe;
  logic [15:0] tx_word;
  logic [3:0]  tx_word_idx;
  logic [15:0] rx_word;
  logic [3:0]  rx_word_idx;
  logic        rx_word_valid, frame_done, frame_error, busy;

  myo_spi_slave #(
    .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS),
    .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sck(sck), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_word(tx_word), .tx_word_idx(tx_word_idx),
    .rx_word(rx_word), .rx_word_idx(rx_word_idx), .rx_word_valid(rx_word_valid),
    .frame_done(frame_done), .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  // Status stream supplied by the board: 0xA000 + index
  assign tx_word = 16'hA000 + {12'h000, tx_word_idx};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          rx_cnt   = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  logic [15:0] rx_got     [0:31];
  logic [3:0]  rx_idx_got [0:31];
  logic [15:0] mosi_words [0:15];
  logic [15:0] miso_words [0:15];
  logic        busy_seen, oe_seen;

  always @(negedge clock) begin
    if (rx_word_valid) begin
      if (rx_cnt < 32) begin
        rx_got[rx_cnt]     = rx_word;
        rx_idx_got[rx_cnt] = rx_word_idx;
      end
      rx_cnt++;
    end
    if (frame_done)  done_cnt++;
    if (frame_error) err_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    @(negedge clock);
    rx_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  task automatic fill_words(input logic [15:0] base);
    for (int i = 0; i < 16; i++) mosi_words[i] = base + 16'(i);
  endtask

  // Mode-0 master: mosi changes with sck low; miso is sampled just before rising
  task automatic spi_frame(input int nwords, input int extra_bits, input bit raise_ss);
    int total;
    total = nwords * WORD_W + extra_bits;
    for (int i = 0; i < 16; i++) miso_words[i] = '0;
    @(negedge clock);
    ss_n = 1'b0;
    repeat (8) @(negedge clock);
    busy_seen = busy;
    oe_seen   = miso_oe;
    for (int b = 0; b < total; b++) begin
      int w;
      int k;
      w = b / WORD_W;
      k = WORD_W - 1 - (b % WORD_W);
      mosi = mosi_words[w][k];
      repeat (4) @(negedge clock);
      miso_words[w][k] = miso;
      sck = 1'b1;
      repeat (4) @(negedge clock);
      sck = 1'b0;
    end
    if (raise_ss) begin
      repeat (8) @(negedge clock);
      ss_n = 1'b1;
      repeat (12) @(negedge clock);
    end
  endtask

  task automatic sck_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sck = 1'b1;
      repeat (4) @(negedge clock);
      sck = 1'b0;
      repeat (4) @(negedge clock);
    end
  endtask

  task automatic report(input string name);
    $display("frame %s: rx_words=%0d done=%0d error=%0d", name, rx_cnt, done_cnt, err_cnt);
  endtask

  initial begin
    int seen;

    // ---------------- reset values ----------------
    repeat (4) @(negedge clock);
    check_val("rst_miso", miso, 0);
    check_val("rst_miso_oe", miso_oe, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_tx_idx", tx_word_idx, 0);
    check_val("rst_rx_word", rx_word, 0);
    check_val("rst_rx_idx", rx_word_idx, 0);
    check_val("rst_valid", rx_word_valid, 0);
    check_val("rst_done", frame_done, 0);
    check_val("rst_error", frame_error, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);

    // ---------------- nominal frame ----------------
    fill_words(16'h1000);
    clear_counts();
    spi_frame(NUM_WORDS, 0, 1'b1);
    report("nominal");
    check_val("nom_busy_in_frame", busy_seen, 1);
    check_val("nom_oe_in_frame", oe_seen, 1);
    check_val("nom_rx_cnt", rx_cnt, 12);
    for (int i = 0; i < NUM_WORDS; i++) begin
      check_val($sformatf("nom_rx_word[%0d]", i), rx_got[i], 32'h1000 + i);
      check_val($sformatf("nom_rx_idx[%0d]", i), rx_idx_got[i], i);
      check_val($sformatf("nom_miso_word[%0d]", i), miso_words[i], 32'hA000 + i);
    end
    check_val("nom_done", done_cnt, 1);
    check_val("nom_error", err_cnt, 0);
    check_val("nom_rx_word_hold", rx_word, 16'h100B);
    check_val("nom_busy_after", busy, 0);
    check_val("nom_oe_after", miso_oe, 0);
    check_val("nom_tx_idx_after", tx_word_idx, 0);

    // ---------------- short frame ----------------
    fill_words(16'h1100);
    clear_counts();
    spi_frame(5, 0, 1'b1);
    report("short");
    check_val("short_rx_cnt", rx_cnt, 5);
    check_val("short_last_word", rx_got[4], 16'h1104);
    check_val("short_last_idx", rx_idx_got[4], 4);
    check_val("short_error", err_cnt, 1);
    check_val("short_done", done_cnt, 0);

    // ---------------- partial word ----------------
    fill_words(16'h1200);
    clear_counts();
    spi_frame(NUM_WORDS, 7, 1'b1);
    report("partial");
    check_val("partial_rx_cnt", rx_cnt, 12);
    check_val("partial_error", err_cnt, 1);
    check_val("partial_done", done_cnt, 0);

    // ---------------- overrun ----------------
    fill_words(16'h1300);
    clear_counts();
    spi_frame(14, 0, 1'b1);
    report("overrun");
    check_val("over_rx_cnt", rx_cnt, 12);
    check_val("over_last_rx", rx_got[11], 16'h130B);
    check_val("over_miso_11", miso_words[11], 16'hA00B);
    check_val("over_miso_12", miso_words[12], 16'h0000);
    check_val("over_miso_13", miso_words[13], 16'h0000);
    check_val("over_error", err_cnt, 1);
    check_val("over_done", done_cnt, 0);

    // ---------------- ss_n glitch without sck ----------------
    clear_counts();
    ss_n = 1'b0;
    repeat (10) @(negedge clock);
    ss_n = 1'b1;
    repeat (12) @(negedge clock);
    report("ss_glitch");
    check_val("glitch_error", err_cnt, 1);
    check_val("glitch_done", done_cnt, 0);
    check_val("glitch_rx_cnt", rx_cnt, 0);

    // ---------------- sck while idle is ignored ----------------
    clear_counts();
    sck_pulses(20);
    check_val("idle_sck_busy", busy, 0);
    check_val("idle_sck_rx_cnt", rx_cnt, 0);
    check_val("idle_sck_oe", miso_oe, 0);
    fill_words(16'h2000);
    spi_frame(NUM_WORDS, 0, 1'b1);
    report("after_idle_sck");
    check_val("idle_sck_frame_done", done_cnt, 1);
    check_val("idle_sck_frame_err", err_cnt, 0);
    check_val("idle_sck_word0", rx_got[0], 16'h2000);
    check_val("idle_sck_word11", rx_got[11], 16'h200B);

    // ---------------- reset mid-frame ----------------
    fill_words(16'h3000);
    clear_counts();
    spi_frame(3, 0, 1'b0);
    check_val("midrst_rx_before", rx_cnt, 3);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_oe", miso_oe, 0);
    check_val("midrst_miso", miso, 0);
    check_val("midrst_tx_idx", tx_word_idx, 0);
    check_val("midrst_rx_word", rx_word, 0);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    // ss_n is still low from the interrupted frame: must be ignored
    sck_pulses(16);
    check_val("midrst_ignored_busy", busy, 0);
    check_val("midrst_ignored_oe", miso_oe, 0);
    check_val("midrst_ignored_rx", rx_cnt, 3);
    ss_n = 1'b1;
    repeat (12) @(negedge clock);
    check_val("midrst_no_done", done_cnt, 0);
    check_val("midrst_no_err", err_cnt, 0);
    fill_words(16'h4000);
    clear_counts();
    spi_frame(NUM_WORDS, 0, 1'b1);
    report("after_reset");
    check_val("postrst_done", done_cnt, 1);
    check_val("postrst_err", err_cnt, 0);
    check_val("postrst_rx_cnt", rx_cnt, 12);
    check_val("postrst_word11", rx_got[11], 16'h400B);
    check_val("postrst_miso0", miso_words[0], 16'hA000);

    // ---------------- stall mid word 2 ----------------
    fill_words(16'h6000);
    clear_counts();
    spi_frame(2, 5, 1'b0);
    check_val("stall_rx_cnt", rx_cnt, 2);
`ifdef MYO_SPI_TIMEOUT_EN
    // Last sck fall reaches the edge detector after SYNC_STAGES+1 cycles.
    // The pulse follows TIMEOUT cycles after that.
    seen = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (frame_error) begin
        seen = c;
        break;
      end
    end
    check_val("stall_timeout_latency", seen, TIMEOUT + SYNC_STAGES + 1);
    check_val("stall_oe", miso_oe, 0);
    check_val("stall_busy", busy, 0);
    ss_n = 1'b1;
    repeat (12) @(negedge clock);
    report("stall_timeout");
    check_val("stall_err_cnt", err_cnt, 1);
    check_val("stall_done_cnt", done_cnt, 0);
`else
    seen = 0;
    repeat (300) @(negedge clock);
    check_val("stall_busy", busy, 1);
    check_val("stall_oe", miso_oe, 1);
    check_val("stall_no_err", err_cnt, 0);
    ss_n = 1'b1;
    repeat (12) @(negedge clock);
    report("stall_release");
    check_val("stall_err_cnt", err_cnt, 1);
    check_val("stall_done_cnt", done_cnt, 0);
`endif
    fill_words(16'h7000);
    clear_counts();
    spi_frame(NUM_WORDS, 0, 1'b1);
    report("after_stall");
    check_val("poststall_done", done_cnt, 1);
    check_val("poststall_err", err_cnt, 0);
    check_val("poststall_miso5", miso_words[5], 16'hA005);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
